// File: rtl/sig_streamer.sv
// Signature dumper: snoops the core's tohost write, halts the core, reads the
// signature region word by word and streams each word as "xxxxxxxx\n" ASCII.
module sig_streamer #(
  parameter logic [31:0] SIG_BEGIN = 32'h0000_5000,
  parameter logic [31:0] SIG_END   = 32'h0000_8000,
  parameter logic [31:0] TOHOST    = 32'h0000_5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  output logic        core_halt,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, HALT, READ, CAPT, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] ptr;
  logic [31:0] sr;
  logic [3:0]  k;

  logic trig, empty, last_word, byte_done, last_char;
  logic unused_addr_lsb;

  assign trig      = mem_we && (mem_waddr[31:2] == TOHOST[31:2]) && (mem_wdata == 32'h0000_0001);
  assign empty     = (SIG_BEGIN[31:2] >= SIG_END[31:2]);
  assign last_word = ((ptr[31:2] + 30'd1) == SIG_END[31:2]);
  assign last_char = (k == 4'd8);
  assign byte_done = tx_valid && tx_ready;
  assign unused_addr_lsb = ^mem_waddr[1:0];

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
    else             hex_char = 8'h57 + {4'h0, nib};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= SIG_BEGIN;
      sr    <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (state == CAPT) begin
        sr <= rd_data;
        k  <= '0;
      end else if (state == SEND && byte_done) begin
        // the top nibble is always the next digit, so shift after each one
        if (last_char) ptr <= ptr + 32'd4;
        else begin
          k  <= k + 4'd1;
          sr <= {sr[27:0], 4'h0};
        end
      end
    end
  end

  // Moore outputs: all decoded from state, so reset clears them asynchronously
  always_comb begin
    state_nxt = state;
    core_halt = 1'b1;
    rd_en     = 1'b0;
    rd_addr   = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        core_halt = 1'b0;
        if (trig) state_nxt = HALT;
      end
      HALT: state_nxt = empty ? DONE : READ;
      READ: begin
        rd_en     = 1'b1;
        rd_addr   = {ptr[31:2], 2'b00};
        state_nxt = CAPT;
      end
      CAPT: state_nxt = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = last_char ? 8'h0A : hex_char(sr[31:28]);
        if (byte_done && last_char) state_nxt = last_word ? DONE : READ;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
